fxp_seq_divider: RTL and testbench

- Parametrised fixed-point sequential restoring divider: full controller, datapath and iteration counter in one block.
- Computes Q = (A << FRAC) / B for WIDTH-bit operands in the same Q(WIDTH-FRAC).FRAC format.
- One quotient bit per clock, with unsigned/signed mode, remainder output, early overflow exit and divide-by-zero detection.
- Serves as the arithmetic-unit-level divider for the datapath.

---
 rtl/fxp_div_pkg.sv | 19 +
 rtl/div_iter_counter.sv | 31 +++
 rtl/fxp_seq_divider.sv | 165 ++++++++++++++++
 tb/tb_fxp_seq_divider.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fxp_div_pkg.sv
// Shared definitions for the fixed-point sequential divider: FSM state
// encodings and the counter-width helper.
package fxp_div_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // Width needed to count 0..iter inclusive.
  function automatic int calc_cw(input int iter);
    return $clog2(iter + 1);
  endfunction

endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter with enable, synchronous clear and a terminal-count flag
// raised while the count equals a programmable value.
module div_iter_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [CW-1:0] tc_val_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == tc_val_i);

endmodule

// File: rtl/fxp_seq_divider.sv
// Restoring fixed-point divider, Q = (A << FRAC) / B, one quotient bit per
// clock on magnitudes, with signed fix-up, divide-by-zero and overflow exits.
module fxp_seq_divider
  import fxp_div_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int FRAC  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             valid,
  output logic             dvz,
  output logic             ovf,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] r_out
);

  localparam int ITER = WIDTH + FRAC;
  localparam int CW   = calc_cw(ITER);
  localparam logic [CW-1:0]    FRAC_C  = CW'(FRAC);
  localparam logic [CW-1:0]    TC_C    = CW'(ITER - 1);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state_q, state_d;
  logic busy_q, busy_d, valid_q, valid_d, dvz_q, dvz_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] q_q, r_q;

  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [ITER-1:0]  dq_q;
  logic             sm_q, neg_q, asign_q;

  logic [CW-1:0]    cnt;
  logic             cnt_tc, cnt_clr, cnt_en, load_res;
  logic [WIDTH:0]   shifted, diff;
  logic             qbit, range_ovf;
  logic [WIDTH-1:0] amag, bmag, mag, q_fix, r_fix;

  div_iter_counter #(.CW(CW)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .tc_val_i (TC_C),
    .cnt_o    (cnt),
    .tc_o     (cnt_tc)
  );

  // Trial subtraction: no borrow (diff MSB clear) means |b| fits.
  always_comb begin
    shifted   = {acc_q, dq_q[ITER-1]};
    diff      = shifted - {1'b0, b_q};
    qbit      = ~diff[WIDTH];
    amag      = (sm_q && a_q[WIDTH-1]) ? (~a_q + 1'b1) : a_q;
    bmag      = (sm_q && b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;
    mag       = dq_q[WIDTH-1:0];
    q_fix     = neg_q   ? (~mag + 1'b1)   : mag;
    r_fix     = asign_q ? (~acc_q + 1'b1) : acc_q;
    range_ovf = sm_q && ((!neg_q && (mag > MAX_POS)) || (neg_q && (mag > MAX_NEG)));
  end

  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    valid_d  = 1'b0;
    dvz_d    = 1'b0;
    ovf_d    = 1'b0;
    load_res = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        if (b_q == '0) begin
          state_d = S_ERR;
          dvz_d   = 1'b1;
        end else begin
          state_d = S_ITER;
          cnt_clr = 1'b1;
        end
      end
      S_ITER: begin
        cnt_en = 1'b1;
        // A 1 among the first FRAC bits lands above the result width.
        if (qbit && (cnt < FRAC_C)) begin
          state_d = S_ERR;
          ovf_d   = 1'b1;
        end else if (cnt_tc) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (range_ovf) begin
          state_d = S_ERR;
          ovf_d   = 1'b1;
        end else begin
          state_d  = S_DONE;
          valid_d  = 1'b1;
          load_res = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      dvz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      dvz_q   <= dvz_d;
      ovf_q   <= ovf_d;
      if (load_res) begin
        q_q <= q_fix;
        r_q <= r_fix;
      end
    end
  end

  // Working datapath carries no reset; it is always reloaded before use.
  always_ff @(posedge clk) begin
    case (state_q)
      S_IDLE: if (start) begin
        a_q  <= a_in;
        b_q  <= b_in;
        sm_q <= signed_mode;
      end
      S_LOAD: begin
        b_q     <= bmag;
        acc_q   <= '0;
        dq_q    <= {amag, {FRAC{1'b0}}};
        neg_q   <= sm_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        asign_q <= sm_q && a_q[WIDTH-1];
      end
      S_ITER: begin
        acc_q <= qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        dq_q  <= {dq_q[ITER-2:0], qbit};
      end
      default: ;
    endcase
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign dvz   = dvz_q;
  assign ovf   = ovf_q;
  assign q_out = q_q;
  assign r_out = r_q;

endmodule

// File: tb/tb_fxp_seq_divider.sv
// Scoreboard bench for fxp_seq_divider at WIDTH=8, FRAC=4.
module tb_fxp_seq_divider;

  localparam int W    = 8;
  localparam int F    = 4;
  localparam int ITER = W + F;

  logic clk, rst_n, start, signed_mode;
  logic [W-1:0] a_in, b_in, q_out, r_out;
  logic busy, valid, dvz, ovf;

  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  typedef struct {
    int kind;
    int lat;
    int t0;
    bit early;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } exp_t;

  exp_t sb[$];

  fxp_seq_divider #(.WIDTH(W), .FRAC(F)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a_in(a_in), .b_in(b_in), .busy(busy), .valid(valid), .dvz(dvz),
    .ovf(ovf), .q_out(q_out), .r_out(r_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // kind: 0 = valid, 1 = dvz, 2 = ovf
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sm, input int t0);
    exp_t e;
    int am, bm, qt, rm;
    bit na, nb, neg;
    e.t0 = t0; e.early = 0; e.q = '0; e.r = '0; e.lat = ITER + 3; e.kind = 0;
    if (b == 0) begin
      e.kind = 1; e.lat = 2;
      return e;
    end
    na = sm && a[W-1];
    nb = sm && b[W-1];
    am = na ? (256 - int'(a)) : int'(a);
    bm = nb ? (256 - int'(b)) : int'(b);
    qt = (am * 16) / bm;
    rm = (am * 16) % bm;
    neg = na ^ nb;
    if (qt > 255) begin
      e.kind = 2; e.early = 1;
    end else if (sm && ((!neg && qt > 127) || (neg && qt > 128))) begin
      e.kind = 2;
    end else begin
      e.q = W'(neg ? (256 - qt) : qt);
      e.r = W'(na ? (256 - rm) : rm);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && (valid || dvz || ovf)) begin
      if (sb.size() == 0) begin
        chk("spurious_pulse", {29'd0, valid, dvz, ovf}, 32'd0);
      end else begin
        automatic exp_t e = sb.pop_front();
        automatic int kind_got = valid ? 0 : (dvz ? 1 : 2);
        automatic int lat = cyc - e.t0;
        chk("kind", kind_got, e.kind);
        chk("onehot", int'(valid) + int'(dvz) + int'(ovf), 1);
        chk("busy_at_result", busy, 1'b1);
        if (e.early) chk("early_ovf_before_T8", (lat < 8), 1'b1);
        else         chk("latency", lat, e.lat);
        if (e.kind == 0) begin
          chk("q_out", q_out, e.q);
          chk("r_out", r_out, e.r);
          last_q = e.q;
          last_r = e.r;
        end else begin
          chk("q_held", q_out, last_q);
          chk("r_held", r_out, last_r);
        end
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout_pending", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
    chk("busy_idle_after", busy, 1'b0);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    a_in = a; b_in = b; signed_mode = sm; start = 1'b1;
    sb.push_back(model(a, b, sm, cyc));
    @(negedge clk);
    start = 1'b0;
    chk("busy_T1", busy, 1'b1);
    wait_drain();
  endtask

  initial begin
    automatic int t0;
    rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_dvz", dvz, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_q", q_out, 8'h00);
    chk("rst_r", r_out, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    issue(8'h30, 8'h20, 1'b0);

    // start held high: second op accepted in the IDLE cycle after valid
    t0 = cyc;
    a_in = 8'h07; b_in = 8'h03; signed_mode = 1'b0; start = 1'b1;
    sb.push_back(model(8'h07, 8'h03, 1'b0, t0));
    sb.push_back(model(8'hD0, 8'h20, 1'b1, t0 + ITER + 4));
    @(negedge clk);
    a_in = 8'hD0; b_in = 8'h20; signed_mode = 1'b1;
    while (cyc < t0 + ITER + 4) @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    issue(8'h55, 8'h00, 1'b0);
    issue(8'hFF, 8'h01, 1'b0);
    issue(8'h80, 8'h10, 1'b1);
    issue(8'h80, 8'hF0, 1'b1);
    issue(8'hD0, 8'h20, 1'b1);
    issue(8'hF9, 8'h03, 1'b1);
    issue(8'h9C, 8'h00, 1'b1);

    for (int i = 0; i < 16; i++)
      issue(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    // asynchronous reset in the middle of an iteration
    a_in = 8'h07; b_in = 8'h03; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_valid", valid, 1'b0);
    chk("arst_dvz", dvz, 1'b0);
    chk("arst_ovf", ovf, 1'b0);
    chk("arst_q", q_out, 8'h00);
    chk("arst_r", r_out, 8'h00);
    last_q = '0; last_r = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(8'h07, 8'h03, 1'b0);
    issue(8'h55, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
